prio_encode_rr: RTL and testbench

PRIO_ENCODE_RR -- requirements
Module: prio_encode_rr

---
 rtl/encode_pkg.sv | 16 +
 rtl/prio_find_first.sv | 30 +++
 rtl/prio_encode_rr.sv | 59 +++++
 tb/tb_prio_encode_rr.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/encode_pkg.sv
// Shared constants and helpers for the priority encoder slice.
package encode_pkg;

    localparam int unsigned ENC_FIXED = 0;
    localparam int unsigned ENC_RR    = 1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational search for the first set bit at or above a start index, wrapping at N-1.
module prio_find_first
    import encode_pkg::*;
#(
    parameter  int unsigned N = 8,
    localparam int unsigned W = clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;

    // Rotating so that 'start' lands at bit 0 turns the wrapped search into a plain lowest-bit search.
    always_comb begin
        dbl = {vec, vec} >> start;
        rot = dbl[N-1:0];
        off = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (rot[i-1]) off = W'(i - 1);
        end
        found = |vec;
        idx   = found ? (start + off) : '0;
    end

endmodule

// File: rtl/prio_encode_rr.sv
// Registered priority encoder, fixed or round-robin, with a one-entry valid/ready output stage.
module prio_encode_rr
    import encode_pkg::*;
#(
    parameter  int unsigned N    = 8,
    parameter  int unsigned MODE = ENC_FIXED,
    localparam int unsigned W    = clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic         out_any,
    output logic         out_multi
);

    logic [W-1:0] ptr;
    logic         found;
    logic [W-1:0] sel_idx;
    logic         multi;
    logic         accept;

    prio_find_first #(.N(N)) u_find (
        .vec   (req),
        .start (ptr),
        .found (found),
        .idx   (sel_idx)
    );

    // Clearing the lowest set bit leaves something behind only when two or more bits were set.
    assign multi    = |(req & (req - 1'b1));
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_any   <= 1'b0;
            out_multi <= 1'b0;
            ptr       <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_code  <= sel_idx;
                out_any   <= found;
                out_multi <= multi;
                if (MODE == ENC_RR && found) ptr <= sel_idx + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prio_encode_rr.sv
// Directed bench driving a fixed-priority and a round-robin instance with identical stimulus.
module tb_prio_encode_rr;
    import encode_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] req;
    logic       out_ready;

    logic       in_ready0, out_valid0, out_any0, out_multi0;
    logic [2:0] out_code0;
    logic       in_ready1, out_valid1, out_any1, out_multi1;
    logic [2:0] out_code1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prio_encode_rr #(.N(8), .MODE(ENC_FIXED)) dut_fixed (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .req(req), .out_valid(out_valid0), .out_ready(out_ready),
        .out_code(out_code0), .out_any(out_any0), .out_multi(out_multi0)
    );

    prio_encode_rr #(.N(8), .MODE(ENC_RR)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .req(req), .out_valid(out_valid1), .out_ready(out_ready),
        .out_code(out_code1), .out_any(out_any1), .out_multi(out_multi1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {valid, code, any, multi} for the fixed instance then the round-robin instance.
    task automatic chk_out(input string tag,
                           input logic v0, input logic [2:0] c0, input logic a0, input logic m0,
                           input logic v1, input logic [2:0] c1, input logic a1, input logic m1);
        chk({tag, " fixed.valid"}, 32'(out_valid0), 32'(v0));
        chk({tag, " fixed.code"},  32'(out_code0),  32'(c0));
        chk({tag, " fixed.any"},   32'(out_any0),   32'(a0));
        chk({tag, " fixed.multi"}, 32'(out_multi0), 32'(m0));
        chk({tag, " rr.valid"},    32'(out_valid1), 32'(v1));
        chk({tag, " rr.code"},     32'(out_code1),  32'(c1));
        chk({tag, " rr.any"},      32'(out_any1),   32'(a1));
        chk({tag, " rr.multi"},    32'(out_multi1), 32'(m1));
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        chk({tag, " fixed.in_ready"}, 32'(in_ready0), 32'(exp));
        chk({tag, " rr.in_ready"},    32'(in_ready1), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        req       = 8'h00;
        out_ready = 1'b1;
        #1;
        chk_out("reset", 0, 3'd0, 0, 0, 0, 3'd0, 0, 0);
        chk_ready("reset", 1'b1);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk_ready("post_reset", 1'b1);
        step();
        chk_out("idle", 0, 3'd0, 0, 0, 0, 3'd0, 0, 0);

        // First accept after reset: both instances search from bit 0; rr ptr -> 3.
        in_valid = 1'b1;
        req      = 8'b1010_0100;
        step();
        chk_out("a4", 1, 3'd2, 1, 1, 1, 3'd2, 1, 1);

        // Zero vector still delivered; rr ptr stays 3.
        req = 8'h00;
        step();
        chk_out("zero", 1, 3'd0, 0, 0, 1, 3'd0, 0, 0);

        req = 8'b1010_0100;
        step();
        chk_out("a4_ptr3", 1, 3'd2, 1, 1, 1, 3'd5, 1, 1);

        // Stall with rr code 5 held; next vector waits at the input.
        out_ready = 1'b0;
        req       = 8'b0000_0011;
        #1;
        chk_ready("stall_pre", 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ready("stall", 1'b0);
            chk_out("stall_hold", 1, 3'd2, 1, 1, 1, 3'd5, 1, 1);
        end
        out_ready = 1'b1;
        #1;
        chk_ready("release", 1'b1);
        step();
        // rr ptr was 6: bits 6,7 clear, wraps to bit 0; ptr -> 1.
        chk_out("wrap", 1, 3'd0, 1, 1, 1, 3'd0, 1, 1);

        step();
        chk_out("ptr1", 1, 3'd0, 1, 1, 1, 3'd1, 1, 1);

        // Reset while a result is held.
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_out("async_rst", 0, 3'd0, 0, 0, 0, 3'd0, 0, 0);
        chk_ready("async_rst", 1'b1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("no_stale", 0, 3'd0, 0, 0, 0, 3'd0, 0, 0);
        end

        // Full request vector: rr walks from 0 after reset.
        in_valid = 1'b1;
        req      = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_out("rr_ff", 1, 3'd0, 1, 1, 1, 3'(i % 8), 1, 1);
        end

        // Single-bit vectors: multi clear; rr ptr was 2.
        req = 8'h80;
        step();
        chk_out("bit7", 1, 3'd7, 1, 0, 1, 3'd7, 1, 0);
        req = 8'h01;
        step();
        chk_out("bit0", 1, 3'd0, 1, 0, 1, 3'd0, 1, 0);

        // Drain: output register empties once consumed with no new accept.
        in_valid = 1'b0;
        step();
        chk_out("drain", 0, 3'd0, 1, 0, 0, 3'd0, 1, 0);
        chk_ready("drain", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
